// File: rtl/spi_slave.sv
// SPI mode-0 responder core: oversamples SCK/CS/MOSI in the clk domain and
// exchanges MSB-first bytes through a one-entry tx holding register.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       SPI_CLK,
    input  logic       SPI_CS,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       underrun,
    input  logic       flag_clr
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d, cs_d;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;
    logic                   hold_valid;
    logic [7:0]             hold_data, tx_shift, rx_shift, load_byte;
    logic [2:0]             bit_cnt;
    logic                   done;
    logic                   load_now;

    // CS synchroniser resets high so a deselected bus never looks like a CS fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_CLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    assign tx_ready  = ~hold_valid;
    assign busy      = (state == ACTIVE);
    assign load_byte = hold_valid ? hold_data : IDLE_BYTE;
    assign load_now  = ((state == IDLE) && cs_fall) ||
                       ((state == ACTIVE) && sck_fall && done && !cs_rise);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            SPI_MISO   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            underrun   <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            done       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            underrun <= (underrun & ~flag_clr) | (load_now & ~hold_valid);

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= ACTIVE;
                        bit_cnt <= '0;
                        done    <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (sck_rise) begin
                        rx_shift <= {rx_shift[6:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {rx_shift[6:0], mosi_s};
                            rx_valid <= 1'b1;
                            done     <= 1'b1;
                        end
                    end
                    if (sck_fall && done) begin
                        done <= 1'b0;
                    end else if (sck_fall && bit_cnt != 3'd0) begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        SPI_MISO <= tx_shift[6];
                    end
                    // A completing byte still pulses rx_valid if CS rises on the same cycle.
                    if (cs_rise) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        done     <= 1'b0;
                        tx_shift <= '0;
                        rx_shift <= '0;
                        SPI_MISO <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (load_now) begin
                tx_shift   <= load_byte;
                SPI_MISO   <= load_byte[7];
                hold_valid <= 1'b0;
            end
            // Accept after load so a same-cycle write lands in hold for the next frame.
            if (tx_valid && !hold_valid) begin
                hold_data  <= tx_data;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule
